// File: rtl/islip_scheduler.sv
// Single-iteration iSLIP crossbar scheduler: a round-robin grant per output, then
// a round-robin accept per input, with the matching registered once per cycle.
module islip_scheduler #(
    parameter int number_ports = 4,
    localparam int PW = $clog2(number_ports)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [number_ports*number_ports-1:0]   request,
    output logic [number_ports*PW-1:0]             destinations,
    output logic [number_ports-1:0]                matched
);

    localparam int N = number_ports;

    // Returns {found, index} of the first set bit of vec, scanning from ptr upward mod N.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] vec, input logic [PW-1:0] ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx_p;
        int            idx;
        res = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            idx_p = idx[PW-1:0];
            if (!res[PW] && vec[idx_p]) res = {1'b1, idx_p};
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (int'(v) == N - 1) ? '0 : v + 1'b1;
    endfunction

    logic [N-1:0][PW-1:0] g_q, g_d;
    logic [N-1:0][PW-1:0] a_q, a_d;
    logic [N-1:0][PW-1:0] dest_q, dest_d;
    logic [N-1:0]         matched_q, matched_d;

    logic [N-1:0][N-1:0]  out_req;     // out_req[j][i]: input i requests output j
    logic [N-1:0]         grant_vld;
    logic [N-1:0][PW-1:0] grant_idx;
    logic [N-1:0][N-1:0]  in_grants;   // in_grants[i][j]: output j granted input i
    logic [N-1:0]         acc_vld;
    logic [N-1:0][PW-1:0] acc_idx;

    always_comb begin
        out_req   = '0;
        grant_vld = '0;
        grant_idx = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                out_req[j][i] = request[i*N + j];
            end
            {grant_vld[j], grant_idx[j]} = rr_pick(out_req[j], g_q[j]);
        end
    end

    always_comb begin
        in_grants = '0;
        acc_vld   = '0;
        acc_idx   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                in_grants[i][j] = grant_vld[j] && (int'(grant_idx[j]) == i);
            end
            {acc_vld[i], acc_idx[i]} = rr_pick(in_grants[i], a_q[i]);
        end
    end

    // Only accepted pairs move pointers; each output grants one input, so each
    // g_d entry is written by at most one accepting input.
    always_comb begin
        g_d       = g_q;
        a_d       = a_q;
        dest_d    = '0;
        matched_d = '0;
        for (int i = 0; i < N; i++) begin
            if (acc_vld[i]) begin
                a_d[i]          = wrap_inc(acc_idx[i]);
                g_d[acc_idx[i]] = wrap_inc(PW'(i));
                dest_d[i]       = acc_idx[i];
                matched_d[i]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q       <= '0;
            a_q       <= '0;
            dest_q    <= '0;
            matched_q <= '0;
        end else begin
            g_q       <= g_d;
            a_q       <= a_d;
            dest_q    <= dest_d;
            matched_q <= matched_d;
        end
    end

    assign destinations = dest_q;
    assign matched      = matched_q;

endmodule

// File: tb/tb_islip_scheduler.sv
// Directed bench for islip_scheduler: the driver queues hand-computed matchings
// and a monitor compares them one cycle later against the registered outputs.
module tb_islip_scheduler;

    logic        clk;
    logic        reset;
    logic [15:0] request;
    logic [7:0]  destinations;
    logic [3:0]  matched;

    logic [11:0] exp_q[$];
    string       name_q[$];
    int          pass_cnt;
    int          total_cnt;

    islip_scheduler #(.number_ports(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .destinations (destinations),
        .matched      (matched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Called at a negedge: drives request, optionally queues the expected result, waits to next negedge.
    task automatic step(input logic [15:0] req, input logic [7:0] d, input logic [3:0] m, input string nm);
        request = req;
        exp_q.push_back({d, m});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input logic [15:0] req);
        reset   = 1'b1;
        request = req;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    // Monitor: a new registered matching is presented after every rising edge.
    initial begin
        logic [11:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, ".dest"}, destinations, e[11:4]);
                check({nm, ".matched"}, {4'b0, matched}, {4'b0, e[3:0]});
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        request   = 16'h0D77;
        #2;
        check("reset.dest", destinations, 8'h00);
        check("reset.matched", {4'b0, matched}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1/2: first match and round-robin desynchronisation
        step(16'h0D77, 8'b00110000, 4'b0101, "s1_edge1");
        step(16'h0D77, 8'b00110001, 4'b0111, "s2_edge2");

        // Scenario 3: single input with two requests
        pulse_reset(16'h0060);
        step(16'h0060, 8'b00000100, 4'b0010, "s3_edge1");
        step(16'h0060, 8'b00001000, 4'b0010, "s3_edge2");

        // Scenario 4: idle cycles hold pointers (g1=2, g2=2, a1=3)
        step(16'h0000, 8'b00000000, 4'b0000, "s4_idle0");
        step(16'h0000, 8'b00000000, 4'b0000, "s4_idle1");
        step(16'h0000, 8'b00000000, 4'b0000, "s4_idle2");
        step(16'h0060, 8'b00000100, 4'b0010, "s4_resume");

        // Scenario 5: full load converges to rotating permutations
        pulse_reset(16'hFFFF);
        step(16'hFFFF, 8'b00000000, 4'b0001, "s5_c1");
        step(16'hFFFF, 8'b00000001, 4'b0011, "s5_c2");
        step(16'hFFFF, 8'b00000110, 4'b0111, "s5_c3");
        step(16'hFFFF, 8'b00011011, 4'b1111, "s5_c4");
        step(16'hFFFF, 8'b01101100, 4'b1111, "s5_c5");
        step(16'hFFFF, 8'b10110001, 4'b1111, "s5_c6");
        step(16'hFFFF, 8'b11000110, 4'b1111, "s5_c7");

        // Scenario 6: asynchronous reset between edges, then replay scenario 1
        #2;
        reset = 1'b1;
        #1;
        check("s6_async.dest", destinations, 8'h00);
        check("s6_async.matched", {4'b0, matched}, 8'h00);
        request = 16'h0D77;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(16'h0D77, 8'b00110000, 4'b0101, "s6_edge1");
        step(16'h0D77, 8'b00110001, 4'b0111, "s6_edge2");

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
